// File: rtl/pipe_hazard_sb.sv
// Tracks in-flight GPR writes from E to W and picks a bypass source or a D stall for each read port.
// Latency: stall/bp_sel/occupancy are combinational from registered slots; slots advance once per unfrozen clock.
// Backpressure: hold freezes every slot and the stall counter; stall or flush puts a bubble into slot 0.
module pipe_hazard_sb #(
    parameter int NSTAGE = 3,
    parameter int AW     = 5,
    parameter int NRD    = 2,
    parameter int LATW   = 2,
    parameter int SELW   = 2,
    parameter int CNTW   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                issue_valid,
    input  logic                issue_wr,
    input  logic [AW-1:0]       issue_waddr,
    input  logic [LATW-1:0]     issue_lat,
    input  logic [NRD*AW-1:0]   rd_addr,
    input  logic [NRD-1:0]      rd_used,
    input  logic                hold,
    input  logic                flush,
    output logic                stall,
    output logic [NRD*SELW-1:0] bp_sel,
    output logic [SELW-1:0]     occupancy,
    output logic [CNTW-1:0]     stall_cnt
);

    // Slot k holds the instruction k stages past D (0 = E, NSTAGE-1 = W).
    logic            vld_q   [NSTAGE];
    logic            wr_q    [NSTAGE];
    logic [AW-1:0]   waddr_q [NSTAGE];
    logic [LATW-1:0] lat_q   [NSTAGE];
    logic            vld_d   [NSTAGE];
    logic            wr_d    [NSTAGE];
    logic [AW-1:0]   waddr_d [NSTAGE];
    logic [LATW-1:0] lat_d   [NSTAGE];

    logic [NRD-1:0]  stall_req;
    logic [NRD-1:0]  hit;
    logic            issue_ok;
    logic [CNTW-1:0] stall_cnt_q;
    logic [CNTW-1:0] stall_cnt_d;

    // Per read port: the youngest matching writer decides; forward if its result is ready, else stall.
    always_comb begin
        stall_req = '0;
        hit       = '0;
        bp_sel    = '0;
        for (int p = 0; p < NRD; p++) begin
            if (rd_used[p] && (rd_addr[p*AW +: AW] != '0)) begin
                for (int k = 0; k < NSTAGE; k++) begin
                    if (!hit[p] && vld_q[k] && wr_q[k] && (waddr_q[k] == rd_addr[p*AW +: AW])) begin
                        hit[p] = 1'b1;
                        if (LATW'(k) >= lat_q[k]) begin
                            bp_sel[p*SELW +: SELW] = SELW'(k + 1);
                        end else begin
                            stall_req[p] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign stall = |stall_req;

    // Count the slots that will still write the register file.
    always_comb begin
        occupancy = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            occupancy = occupancy + SELW'(vld_q[k] && wr_q[k]);
        end
    end

    // Next slot contents: shift toward W; slot 0 takes the D instruction only if it can leave D.
    assign issue_ok = issue_valid && !stall && !flush;

    always_comb begin
        vld_d[0]   = issue_ok;
        wr_d[0]    = issue_wr;
        waddr_d[0] = issue_waddr;
        lat_d[0]   = issue_lat;
        for (int k = 1; k < NSTAGE; k++) begin
            vld_d[k]   = vld_q[k-1];
            wr_d[k]    = wr_q[k-1];
            waddr_d[k] = waddr_q[k-1];
            lat_d[k]   = lat_q[k-1];
        end
    end

    // Slot registers; hold freezes the whole back end, reset drops every in-flight write at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSTAGE; k++) begin
                vld_q[k]   <= 1'b0;
                wr_q[k]    <= 1'b0;
                waddr_q[k] <= '0;
                lat_q[k]   <= '0;
            end
        end else if (!hold) begin
            for (int k = 0; k < NSTAGE; k++) begin
                vld_q[k]   <= vld_d[k];
                wr_q[k]    <= wr_d[k];
                waddr_q[k] <= waddr_d[k];
                lat_q[k]   <= lat_d[k];
            end
        end
    end

    // Stall cycles that actually cost a cycle (not frozen), saturating at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !hold && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNTW'(1);
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

    // An issue latency naming a slot past W can never become available.
    a_issue_lat_legal: assert property (@(posedge clk) disable iff (!rst_n)
        issue_valid |-> (int'(issue_lat) < NSTAGE));

endmodule
